// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared constants, state encoding and helpers for the RV32M unit
package ex_muldiv_pkg;

    localparam int RegBus = 32;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    // Instruction category code the decoder uses to raise start_i.
    localparam logic [3:0] CATAGORY_MULDIV = 4'h6;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic [RegBus-1:0] md_cond_neg(input logic [RegBus-1:0] v, input logic neg);
        return neg ? ({RegBus{1'b0}} - v) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - operand/result bundle between ID/EX and the multiply/divide unit
interface ex_muldiv_if import ex_muldiv_pkg::*; ;
    logic              flush_i;
    logic              start_i;
    logic [2:0]        md_op_i;
    logic [RegBus-1:0] rs1_i;
    logic [RegBus-1:0] rs2_i;
    logic              stall_req_o;
    logic              done_o;
    logic [RegBus-1:0] result_o;

    modport master (
        output flush_i, start_i, md_op_i, rs1_i, rs2_i,
        input  stall_req_o, done_o, result_o
    );

    modport slave (
        input  flush_i, start_i, md_op_i, rs1_i, rs2_i,
        output stall_req_o, done_o, result_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide for the EX stage, 32 iterations per op
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   md
);

    md_state_e         r_state;
    logic [4:0]        r_cnt;
    logic [2:0]        r_op;
    logic [RegBus-1:0] r_opb;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [63:0]       r_acc;
    logic              r_done;
    logic [RegBus-1:0] r_result;

    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [RegBus-1:0] w_a_mag;
    logic [RegBus-1:0] w_b_mag;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [RegBus-1:0] w_special_res;

    assign w_a_signed = (md.md_op_i == MD_MULH) || (md.md_op_i == MD_MULHSU)
                     || (md.md_op_i == MD_DIV)  || (md.md_op_i == MD_REM);
    assign w_b_signed = (md.md_op_i == MD_MULH) || (md.md_op_i == MD_DIV)
                     || (md.md_op_i == MD_REM);
    assign w_a_neg    = w_a_signed & md.rs1_i[RegBus-1];
    assign w_b_neg    = w_b_signed & md.rs2_i[RegBus-1];
    assign w_a_mag    = md_cond_neg(md.rs1_i, w_a_neg);
    assign w_b_mag    = md_cond_neg(md.rs2_i, w_b_neg);

    assign w_div_zero = md.md_op_i[2] && (md.rs2_i == 32'd0);
    assign w_div_ovf  = ((md.md_op_i == MD_DIV) || (md.md_op_i == MD_REM))
                     && (md.rs1_i == 32'h8000_0000) && (md.rs2_i == 32'hFFFF_FFFF);

    // op[1] separates REM/REMU from DIV/DIVU among the divide funct3 codes.
    always_comb begin
        w_special_res = 32'd0;
        if (w_div_zero)
            w_special_res = md.md_op_i[1] ? md.rs1_i : 32'hFFFF_FFFF;
        else if (w_div_ovf)
            w_special_res = md.md_op_i[1] ? 32'd0 : 32'h8000_0000;
    end

    // Multiply: acc[63:32] accumulates, acc[31:0] holds the shifting multiplier.
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: acc[63:32] partial remainder, acc[31:0] dividend shifting into quotient.
    logic [32:0] w_rem_sh;
    logic [31:0] w_rem_sub;
    logic        w_q_bit;
    logic [63:0] w_div_next;
    assign w_rem_sh   = r_acc[63:31];
    assign w_q_bit    = (w_rem_sh >= {1'b0, r_opb});
    assign w_rem_sub  = w_rem_sh[31:0] - r_opb;
    assign w_div_next = {(w_q_bit ? w_rem_sub : w_rem_sh[31:0]), r_acc[30:0], w_q_bit};

    logic [63:0]       w_acc_next;
    logic [63:0]       w_prod;
    logic [RegBus-1:0] w_quo;
    logic [RegBus-1:0] w_rem;
    logic [RegBus-1:0] w_final;

    assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;
    assign w_prod     = r_neg_q ? (64'd0 - w_mul_next) : w_mul_next;
    assign w_quo      = md_cond_neg(w_div_next[31:0], r_neg_q);
    assign w_rem      = md_cond_neg(w_div_next[63:32], r_neg_r);

    always_comb begin
        w_final = 32'd0;
        case (r_op)
            MD_MUL:                      w_final = w_prod[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[63:32];
            MD_DIV, MD_DIVU:             w_final = w_quo;
            default:                     w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= MD_IDLE;
            r_cnt    <= 5'd0;
            r_op     <= 3'd0;
            r_opb    <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= 64'd0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else if (md.flush_i) begin
            r_state <= MD_IDLE;
            r_cnt   <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    r_done <= 1'b0;
                    if (md.start_i) begin
                        r_op    <= md.md_op_i;
                        r_opb   <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_acc   <= {32'd0, w_a_mag};
                        r_cnt   <= 5'd0;
                        if (w_div_zero || w_div_ovf) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= MD_DONE;
                        end else begin
                            r_state <= MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                        r_state  <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= MD_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign md.stall_req_o = ((r_state == MD_IDLE) && md.start_i && !md.flush_i)
                         || (r_state == MD_BUSY);
    assign md.done_o      = r_done;
    assign md.result_o    = r_result;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed-vector bench for ex_muldiv
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if md_bus();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst),
        .md  (md_bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input bit release_after, output int done_cyc);
        int lat;
        int stall_cnt;
        @(posedge clk); #1;
        md_bus.start_i = 1'b1;
        md_bus.md_op_i = op;
        md_bus.rs1_i   = a;
        md_bus.rs2_i   = b;
        #1;
        check({tag, "_stall_t0"}, 32'(md_bus.stall_req_o), 32'd1);
        stall_cnt = md_bus.stall_req_o ? 1 : 0;
        lat = 0;
        while (!md_bus.done_o && lat < 100) begin
            @(posedge clk); #2;
            lat++;
            if (!md_bus.done_o && md_bus.stall_req_o) stall_cnt++;
        end
        done_cyc = cyc;
        check({tag, "_done"},       32'(md_bus.done_o), 32'd1);
        check({tag, "_latency"},    32'(lat), 32'(exp_lat));
        check({tag, "_stall_cyc"},  32'(stall_cnt), 32'(exp_lat));
        check({tag, "_result"},     md_bus.result_o, exp);
        check({tag, "_stall_done"}, 32'(md_bus.stall_req_o), 32'd0);
        if (release_after) begin
            @(posedge clk); #1;
            md_bus.start_i = 1'b0;
            #1;
            check({tag, "_done_after"},  32'(md_bus.done_o), 32'd0);
            check({tag, "_stall_after"}, 32'(md_bus.stall_req_o), 32'd0);
            check({tag, "_result_hold"}, md_bus.result_o, exp);
        end
    endtask

    typedef struct {
        string      tag;
        logic [2:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int d1;
        int d2;
        int dn;
        int spurious;

        rst            = 1'b1;
        md_bus.flush_i = 1'b0;
        md_bus.start_i = 1'b0;
        md_bus.md_op_i = 3'd0;
        md_bus.rs1_i   = 32'd0;
        md_bus.rs2_i   = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_done",   32'(md_bus.done_o), 32'd0);
        check("reset_result", md_bus.result_o, 32'd0);
        check("reset_stall",  32'(md_bus.stall_req_o), 32'd0);
        #1 rst = 1'b0;

        vecs.push_back('{"mul_7x6",     MD_MUL,    32'd7,          32'd6,          32'd42,         33});
        vecs.push_back('{"mulh_m1m1",   MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  33});
        vecs.push_back('{"mulhu_ff",    MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33});
        vecs.push_back('{"mulhsu_m1x2", MD_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{"div_m7_2",    MD_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
        vecs.push_back('{"rem_m7_2",    MD_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{"divu_100_7",  MD_DIVU,   32'd100,        32'd7,          32'd14,         33});
        vecs.push_back('{"remu_100_7",  MD_REMU,   32'd100,        32'd7,          32'd2,          33});
        vecs.push_back('{"div_5_0",     MD_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{"remu_5_0",    MD_REMU,   32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{"div_ovf",     MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vecs.push_back('{"rem_ovf",     MD_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});

        foreach (vecs[i])
            run_op(vecs[i].tag, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1, dn);

        // Flush while BUSY with count = 10.
        @(posedge clk); #1;
        md_bus.start_i = 1'b1;
        md_bus.md_op_i = MD_DIVU;
        md_bus.rs1_i   = 32'd1000;
        md_bus.rs2_i   = 32'd7;
        repeat (11) @(posedge clk);
        #1 md_bus.flush_i = 1'b1;
        @(posedge clk); #1;
        md_bus.flush_i = 1'b0;
        md_bus.start_i = 1'b0;
        #1;
        check("flush_stall", 32'(md_bus.stall_req_o), 32'd0);
        check("flush_done",  32'(md_bus.done_o), 32'd0);
        spurious = 0;
        repeat (30) begin
            @(posedge clk); #2;
            if (md_bus.done_o || md_bus.stall_req_o) spurious++;
        end
        check("flush_quiet", 32'(spurious), 32'd0);
        run_op("divu_9_3", MD_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b1, dn);

        // Reset in the middle of BUSY.
        @(posedge clk); #1;
        md_bus.start_i = 1'b1;
        md_bus.md_op_i = MD_MULHU;
        md_bus.rs1_i   = 32'h1234_5678;
        md_bus.rs2_i   = 32'h9ABC_DEF0;
        repeat (6) @(posedge clk);
        #1;
        rst            = 1'b1;
        md_bus.start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_mid_done",   32'(md_bus.done_o), 32'd0);
        check("rst_mid_result", md_bus.result_o, 32'd0);
        check("rst_mid_stall",  32'(md_bus.stall_req_o), 32'd0);

        // Back-to-back: second op starts the cycle after the first DONE.
        run_op("b2b_mul_3x3",  MD_MUL, 32'd3,  32'd3, 32'd9, 33, 1'b0, d1);
        run_op("b2b_rem_10_4", MD_REM, 32'd10, 32'd4, 32'd2, 33, 1'b1, d2);
        check("b2b_spacing", 32'(d2 - d1), 32'd34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
